// File: rtl/filter_mutex_pkg.sv
// Shared types and helpers for the N-process Peterson filter-lock model.
package filter_mutex_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    localparam int unsigned NPROC_DEF = 4;
    localparam int unsigned PID_W_DEF = clog2(NPROC_DEF);

    typedef logic [PID_W_DEF-1:0] pid_t;
    typedef logic [PID_W_DEF-1:0] level_t;

    typedef enum logic [2:0] {
        PC_IDLE,
        PC_SET_LVL,
        PC_SET_VIC,
        PC_WAIT,
        PC_CS,
        PC_EXIT
    } pc_e;

endpackage

// File: rtl/filter_mutex_if.sv
// Scheduler inputs and observation outputs of the filter-lock model.
interface filter_mutex_if #(
    parameter int unsigned NPROC = 4,
    parameter int unsigned PID_W = 2,
    parameter int unsigned CNT_W = 8
);
    logic [PID_W-1:0]       select;
    logic                   pause;
    logic [NPROC-1:0]       in_cs;
    logic [NPROC*PID_W-1:0] cur_level;
    logic [CNT_W-1:0]       cs_entries;
    logic                   mutex_err;
    logic                   starve_err;

    modport master (
        output select, pause,
        input  in_cs, cur_level, cs_entries, mutex_err, starve_err
    );

    modport slave (
        input  select, pause,
        output in_cs, cur_level, cs_entries, mutex_err, starve_err
    );
endinterface

// File: rtl/filter_mutex_n_chk.sv
// At-most-one-hot monitor with a sticky error flag and embedded properties.
module mutex_onehot_chk #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic [N-1:0] vec,
    output logic         err
);
    logic multi_c;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_c = (vec & (vec - N'(1))) != '0;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= err | multi_c;
    end

    a_at_most_one: assert property (@(posedge clock) disable iff (!rst_n) !multi_c);
    a_err_quiet:   assert property (@(posedge clock) disable iff (!rst_n) !err);
endmodule

// File: rtl/filter_mutex_n.sv
// Peterson filter lock for NPROC processes; one process advances per clock.
module filter_mutex_n
    import filter_mutex_pkg::*;
#(
    parameter int unsigned NPROC      = 4,
    parameter int unsigned PID_W      = clog2(NPROC),
    parameter int unsigned WAIT_LIMIT = 63,
    parameter int unsigned CNT_W      = 8
) (
    input logic           clock,
    input logic           rst_n,
    filter_mutex_if.slave bus
);
    localparam int unsigned WAIT_W = clog2(WAIT_LIMIT + 1);
    localparam int unsigned NVIC   = 1 << PID_W;

    logic [PID_W-1:0]       victim_q [NVIC];
    logic [NPROC-1:0]       in_cs_c, vic_we_c, exit_c, starve_c;
    logic [NPROC*PID_W-1:0] level_flat, lvl_flat;
    logic [CNT_W-1:0]       cs_q;
    logic                   starve_q, mutex_q;
    logic                   vic_en_c;
    logic [PID_W-1:0]       vic_idx_c, vic_pid_c;

    for (genvar gi = 0; gi < NPROC; gi++) begin : g_proc
        localparam logic [PID_W-1:0] ID = PID_W'(gi);

        pc_e              pc_q, pc_d;
        logic [PID_W-1:0] lvl_q, lvl_d, level_q, level_d;
        logic [WAIT_W-1:0] wait_q, wait_d;
        logic             step_c, pass_c, others_c, vic_we, exit_s;

        assign step_c = (bus.select == ID);

        // Blocked only while victim at this level and someone else is at or above it.
        always_comb begin
            others_c = 1'b0;
            for (int k = 0; k < NPROC; k++) begin
                if (k != int'(gi) && level_flat[k*PID_W +: PID_W] >= lvl_q) others_c = 1'b1;
            end
            pass_c = (victim_q[lvl_q] != ID) || !others_c;
        end

        always_comb begin
            pc_d    = pc_q;
            lvl_d   = lvl_q;
            wait_d  = wait_q;
            level_d = level_q;
            vic_we  = 1'b0;
            exit_s  = 1'b0;
            if (step_c) begin
                unique case (pc_q)
                    PC_IDLE: if (!bus.pause) begin
                        pc_d  = PC_SET_LVL;
                        lvl_d = PID_W'(1);
                    end
                    PC_SET_LVL: begin
                        level_d = lvl_q;
                        pc_d    = PC_SET_VIC;
                    end
                    PC_SET_VIC: begin
                        vic_we = 1'b1;
                        pc_d   = PC_WAIT;
                    end
                    PC_WAIT: begin
                        if (pass_c) begin
                            wait_d = '0;
                            if (lvl_q == PID_W'(NPROC - 1)) begin
                                pc_d = PC_CS;
                            end else begin
                                lvl_d = lvl_q + PID_W'(1);
                                pc_d  = PC_SET_LVL;
                            end
                        end else if (wait_q != WAIT_W'(WAIT_LIMIT)) begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                    end
                    PC_CS: if (!bus.pause) pc_d = PC_EXIT;
                    PC_EXIT: begin
                        level_d = '0;
                        pc_d    = PC_IDLE;
                        exit_s  = 1'b1;
                    end
                    default: pc_d = PC_IDLE;
                endcase
            end
        end

        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                pc_q    <= PC_IDLE;
                lvl_q   <= PID_W'(1);
                wait_q  <= '0;
                level_q <= '0;
            end else begin
                pc_q    <= pc_d;
                lvl_q   <= lvl_d;
                wait_q  <= wait_d;
                level_q <= level_d;
            end
        end

        assign in_cs_c[gi]                  = (pc_q == PC_CS);
        assign vic_we_c[gi]                 = vic_we;
        assign exit_c[gi]                   = exit_s;
        assign starve_c[gi]                 = (wait_d == WAIT_W'(WAIT_LIMIT));
        assign level_flat[gi*PID_W +: PID_W] = level_q;
        assign lvl_flat[gi*PID_W +: PID_W]   = lvl_q;
    end

    // At most one process is stepped, so at most one victim write request exists.
    always_comb begin
        vic_en_c  = 1'b0;
        vic_idx_c = '0;
        vic_pid_c = '0;
        for (int k = 0; k < NPROC; k++) begin
            if (vic_we_c[k]) begin
                vic_en_c  = 1'b1;
                vic_idx_c = lvl_flat[k*PID_W +: PID_W];
                vic_pid_c = PID_W'(k);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < NVIC; v++) victim_q[v] <= '0;
            cs_q     <= '0;
            starve_q <= 1'b0;
        end else begin
            if (vic_en_c) victim_q[vic_idx_c] <= vic_pid_c;
            if (|exit_c && cs_q != '1) cs_q <= cs_q + CNT_W'(1);
            if (|starve_c) starve_q <= 1'b1;
        end
    end

    mutex_onehot_chk #(.N(NPROC)) u_mutex_chk (
        .clock (clock),
        .rst_n (rst_n),
        .vec   (in_cs_c),
        .err   (mutex_q)
    );

    assign bus.in_cs      = in_cs_c;
    assign bus.cur_level  = level_flat;
    assign bus.cs_entries = cs_q;
    assign bus.mutex_err  = mutex_q;
    assign bus.starve_err = starve_q;
endmodule

// File: tb/tb_filter_mutex_n.sv
// Scoreboard bench: a process-level reference model predicts every cycle's outputs.
module tb_filter_mutex_n;
    import filter_mutex_pkg::*;

    localparam int unsigned NP  = 4;
    localparam int unsigned PW  = 2;
    localparam int unsigned CW  = 8;
    localparam int unsigned WL  = 63;
    localparam int unsigned NP3 = 3;

    localparam int M_IDLE = 0, M_LVL = 1, M_VIC = 2, M_WAIT = 3, M_CS = 4, M_EXIT = 5;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    filter_mutex_if #(.NPROC(NP),  .PID_W(PW), .CNT_W(CW)) bus  ();
    filter_mutex_if #(.NPROC(NP3), .PID_W(PW), .CNT_W(CW)) bus3 ();

    filter_mutex_n #(.NPROC(NP), .WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clock (clock), .rst_n (rst_n), .bus (bus)
    );
    filter_mutex_n #(.NPROC(NP3), .WAIT_LIMIT(WL), .CNT_W(CW)) dut3 (
        .clock (clock), .rst_n (rst_n), .bus (bus3)
    );

    typedef struct packed {
        logic [NP-1:0]    in_cs;
        logic [NP*PW-1:0] lvl;
        logic [CW-1:0]    cs;
        logic             mtx;
        logic             stv;
    } obs_t;

    int   m_pc [NP];
    int   m_level [NP];
    int   m_victim [NP];
    int   m_lc [NP];
    int   m_wc [NP];
    int   m_cs;
    bit   m_mutex, m_starve;
    obs_t exp_q [$];
    int   checks = 0;
    int   failures = 0;

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_pc[i] = M_IDLE; m_level[i] = 0; m_victim[i] = 0; m_lc[i] = 1; m_wc[i] = 0;
        end
        m_cs = 0; m_mutex = 0; m_starve = 0;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o = '0;
        for (int i = 0; i < NP; i++) begin
            o.in_cs[i] = (m_pc[i] == M_CS);
            o.lvl[i*PW +: PW] = PW'(m_level[i]);
        end
        o.cs  = CW'(m_cs);
        o.mtx = m_mutex;
        o.stv = m_starve;
        return o;
    endfunction

    // Filter lock rules applied to the one process the scheduler picked.
    task automatic model_step(input int i, input bit p);
        int ncs;
        bit pass;
        ncs = 0;
        for (int k = 0; k < NP; k++) if (m_pc[k] == M_CS) ncs++;
        if (ncs > 1) m_mutex = 1;
        if (i < NP) begin
            case (m_pc[i])
                M_IDLE: if (!p) begin m_pc[i] = M_LVL; m_lc[i] = 1; end
                M_LVL:  begin m_level[i] = m_lc[i]; m_pc[i] = M_VIC; end
                M_VIC:  begin m_victim[m_lc[i]] = i; m_pc[i] = M_WAIT; end
                M_WAIT: begin
                    pass = 1;
                    if (m_victim[m_lc[i]] == i)
                        for (int k = 0; k < NP; k++) if (k != i && m_level[k] >= m_lc[i]) pass = 0;
                    if (pass) begin
                        m_wc[i] = 0;
                        if (m_lc[i] == NP - 1) m_pc[i] = M_CS;
                        else begin m_lc[i]++; m_pc[i] = M_LVL; end
                    end else begin
                        if (m_wc[i] < WL) m_wc[i]++;
                        if (m_wc[i] == WL) m_starve = 1;
                    end
                end
                M_CS:   if (!p) m_pc[i] = M_EXIT;
                M_EXIT: begin
                    m_level[i] = 0; m_pc[i] = M_IDLE;
                    if (m_cs < 255) m_cs++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int sel, input bit p);
        @(negedge clock);
        bus.select = PW'(sel);
        bus.pause  = p;
        model_step(sel, p);
        exp_q.push_back(model_obs());
    endtask

    task automatic peek();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        chk("rst_in_cs", 32'(bus.in_cs), 0);
        chk("rst_cur_level", 32'(bus.cur_level), 0);
        chk("rst_cs_entries", 32'(bus.cs_entries), 0);
        chk("rst_errs", {30'd0, bus.mutex_err, bus.starve_err}, 0);
        exp_q.delete();
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        bus.select = '0;
        bus.pause  = 1'b1;
        model_step(0, 1);
        exp_q.push_back(model_obs());
    endtask

    // Monitor: every post-edge observation is checked against the next prediction.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clock);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.in_cs, bus.cur_level, bus.cs_entries, bus.mutex_err, bus.starve_err};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, a, e);
                end
                checks++;
                if ($countones(bus.in_cs) > 1) begin
                    failures++;
                    $display("FAIL exclusion t=%0t actual in_cs=%b required at most one", $time, bus.in_cs);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int others [3];
        others = '{0, 1, 3};
        bus.select = '0; bus.pause = 1'b1;
        bus3.select = PW'(3); bus3.pause = 1'b0;
        model_reset();
        do_reset();

        // Solo run of p0
        for (int c = 0; c < 10; c++) drive(0, 0);
        peek();
        chk("solo_in_cs", 32'(bus.in_cs), 32'h1);
        chk("solo_level", 32'(bus.cur_level), 32'h3);
        for (int c = 0; c < 2; c++) drive(0, 0);
        peek();
        chk("solo_exit_in_cs", 32'(bus.in_cs), 0);
        chk("solo_entries", 32'(bus.cs_entries), 1);

        // Reset while p0 is in its critical section
        for (int c = 0; c < 10; c++) drive(0, 0);
        peek();
        chk("midcs_in_cs", 32'(bus.in_cs), 32'h1);
        do_reset();
        drive(0, 1);
        peek();
        chk("post_rst_level", 32'(bus.cur_level), 0);

        // Round-robin contention
        for (int c = 0; c < 2000; c++) drive(c % NP, 0);
        peek();
        chk("rr_mutex", 32'(bus.mutex_err), 0);
        chk("rr_entries_ge4", 32'(bus.cs_entries >= CW'(4)), 1);

        // p1 parked as victim at level 1 while p0 holds the section
        do_reset();
        for (int c = 0; c < 3; c++) drive(0, 0);
        for (int c = 0; c < 3; c++) drive(1, 0);
        for (int c = 0; c < 7; c++) drive(0, 0);
        peek();
        chk("victim_p0_cs", 32'(bus.in_cs), 32'h1);
        for (int c = 0; c < int'(WL) - 1; c++) drive(1, 0);
        peek();
        chk("starve_before", 32'(bus.starve_err), 0);
        drive(1, 0);
        peek();
        chk("starve_at_limit", 32'(bus.starve_err), 1);
        chk("starve_p0_held", 32'(bus.in_cs), 32'h1);

        // Pause holds p2 in its critical section while the rest pile up
        do_reset();
        for (int c = 0; c < 10; c++) drive(2, 0);
        for (int c = 0; c < 60; c++) drive(others[c % 3], 0);
        for (int c = 0; c < 50; c++) begin
            drive(2, 1);
            drive(others[c % 3], 1);
        end
        peek();
        chk("pause_in_cs", 32'(bus.in_cs), 32'h4);
        chk("pause_mutex", 32'(bus.mutex_err), 0);
        for (int c = 0; c < 400; c++) drive(c % NP, 0);

        // Randomised scheduling and pauses
        for (int c = 0; c < 1500; c++) drive(int'($urandom_range(0, NP - 1)), ($urandom_range(0, 3) == 0));
        peek();
        chk("rand_mutex", 32'(bus.mutex_err), 0);

        // Out-of-range select on the three-process instance changes nothing
        do_reset();
        for (int c = 0; c < 7; c++) begin drive(0, 1); bus3.select = '0; end
        peek();
        chk("np3_cs", 32'(bus3.in_cs), 32'h1);
        for (int c = 0; c < 20; c++) begin drive(0, 1); bus3.select = PW'(3); end
        peek();
        chk("np3_hold_cs", 32'(bus3.in_cs), 32'h1);
        chk("np3_hold_level", 32'(bus3.cur_level), 32'h2);
        chk("np3_hold_entries", 32'(bus3.cs_entries), 0);
        for (int c = 0; c < 2; c++) begin drive(0, 1); bus3.select = '0; end
        peek();
        chk("np3_exit_entries", 32'(bus3.cs_entries), 1);
        chk("np3_exit_cs", 32'(bus3.in_cs), 0);
        bus3.select = PW'(3);

        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clock);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
